qar_can_tx_sched: RTL and testbench
===================================

# qar_can_tx_sched

Transmit scheduler in front of the `qar_can` register block. It holds one mailbox per requester and always picks the pending frame with the lowest CAN identifier, lowest index on ties. It sequences that frame into the CAN block through the CAN block's word-addressed register port, then polls for completion and reports the result. It is the only master on that port while it is busy.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters/mailboxes (2..8).
- `TIMEOUT_CYC`, 255: maximum POLL cycles before an error completion (1..65535).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: allows new frames to start; an in-flight frame always finishes.
- `req_valid` in N_REQ: per-requester frame offer.
- `req_ready` out N_REQ: mailbox i empty.
- `req_id` in 32·N_REQ: identifier; only [28:0] is used.
- `req_dlc` in 4·N_REQ: data length code.
- `req_data0` in 32·N_REQ: payload bytes 0-3.
- `req_data1` in 32·N_REQ: payload bytes 4-7.
- `done_valid` out 1: one-cycle completion pulse.
- `done_idx` out 3: requester index that completed.
- `done_err` out 1: completion was a timeout.
- `busy` out 1: FSM is not in IDLE.
- `can_write` out 1: write strobe to the CAN block.
- `can_read` out 1: read strobe to the CAN block.
- `can_addr` out 6: register word address.
- `can_wdata` out 32: write data.
- `can_rdata` in 32: combinational read data from the CAN block.

## Operation
**Mailboxes**
- Mailbox i accepts a frame when `req_valid[i] & req_ready[i]`. It latches id, dlc, data0 and data1, and becomes full on the next cycle.
- A full mailbox is cleared only in DONE, when it is the selected mailbox.
- Accepts into other mailboxes continue while a frame is in flight. They never preempt it.

**Arbitration** (IDLE only, when `enable=1` and at least one mailbox is full)
- Select the full mailbox with the minimum `id[28:0]`. On equal ids, the lowest index wins.
- Register the selection as `sel`.

**FSM**: IDLE → WR_ID → WR_DLC → WR_D0 → WR_D1 → WR_GO → POLL → DONE → IDLE.
- WR_ID: write `{3'b0,id[28:0]}` to address 0x8.
- WR_DLC: write `{28'b0,min(dlc,8)}` to address 0x9. A dlc of 9..15 is clamped to 8.
- WR_D0: write data0 to address 0xA.
- WR_D1: write data1 to address 0xB.
- WR_GO: write 32'h0 to address 0xC (transmit trigger).
- POLL: `can_read=1`, address 0x1. If `can_rdata[1]` (TX done) is 1, go to DONE with err=0. Otherwise increment the poll counter. When the counter reaches `TIMEOUT_CYC`, go to DONE with err=1.
- DONE: pulse `done_valid` with `done_idx=sel` and `done_err`, clear mailbox `sel`, return to IDLE.

**Bus rules**
- Never read address 0xD; reading it pops the RX FIFO.
- `can_write` and `can_read` are never both high.
- When neither strobe is high, `can_addr` and `can_wdata` are 0.

## Timing
- All outputs are registered except `req_ready`, which is a direct decode of the mailbox full flags.
- Reset values: all mailboxes empty, so `req_ready` is all ones; `done_valid=0`, `done_idx=0`, `done_err=0`, `busy=0`, `can_write=0`, `can_read=0`, `can_addr=0`, `can_wdata=0`; FSM in IDLE; poll counter 0.
- Latency with an idle FSM:
  - Accept in cycle k.
  - Mailbox full in k+1; arbitration in k+1.
  - WR_ID in k+2, WR_GO in k+6, first POLL in k+7.
  - Earliest `done_valid` in k+8; `req_ready[i]` high again in k+9.
  - Minimum frame-to-frame spacing is 8 cycles.
- Back-to-back: IDLE re-arbitrates in the cycle after DONE. A mailbox refilled in that same cycle competes normally.
- `enable` falling mid-frame has no effect until the FSM returns to IDLE.
- Poll counter: 16 bits, cleared on entry to POLL, saturating. A timeout completes after exactly `TIMEOUT_CYC+1` POLL cycles.
- An asynchronous reset mid-frame aborts the frame with no `done_valid`. The CAN block shares `rst_n`.

## Structure
- Shared package `qar_can_pkg` holds:
  - register word addresses CTRL=0x0, STATUS=0x1, TX_ID=0x8, TX_DLC=0x9, TX_D0=0xA, TX_D1=0xB, TX_GO=0xC, RX_ID=0xD;
  - STATUS_TX_DONE_BIT=1;
  - the scheduler state encoding.
- One sub-module: `qar_can_prio_sel`, a combinational minimum-id / lowest-index selector over N_REQ entries, output `{found, idx}`.

## Test plan
- Single frame: requester 2 offers id=0x123, dlc=4, d0=0xDEADBEEF, d1=0 → exact write sequence 0x8/0x123, 0x9/4, 0xA/0xDEADBEEF, 0xB/0, 0xC/0; one POLL; `done_valid` with `idx=2`, `err=0` at k+8.
- Priority: mailboxes 0..3 filled with ids 0x300, 0x100, 0x100, 0x050 in one cycle → completion order 3, 1, 2, 0.
- DLC clamp: dlc=13 → 0x9 write data equals 8.
- Timeout: CAN model holds status[1]=0 with TIMEOUT_CYC=10 → 11 POLL cycles, then `done_err=1`, mailbox cleared.
- Enable/reset: `enable=0` with a full mailbox keeps busy=0 and issues no strobes. Raising `enable` starts the frame. Asserting `rst_n=0` during WR_D0 gives all outputs at reset values, `req_ready` all ones, and no done pulse.

Source files
------------

// File: rtl/qar_can_pkg.sv
// qar_can_pkg: CAN register map, status bits and tx scheduler state encoding
package qar_can_pkg;
  localparam logic [5:0] A_CTRL   = 6'h0;
  localparam logic [5:0] A_STATUS = 6'h1;
  localparam logic [5:0] A_TX_ID  = 6'h8;
  localparam logic [5:0] A_TX_DLC = 6'h9;
  localparam logic [5:0] A_TX_D0  = 6'hA;
  localparam logic [5:0] A_TX_D1  = 6'hB;
  localparam logic [5:0] A_TX_GO  = 6'hC;
  localparam logic [5:0] A_RX_ID  = 6'hD;
  localparam int STATUS_TX_DONE_BIT = 1;
  typedef enum logic [2:0] {
    S_IDLE, S_WR_ID, S_WR_DLC, S_WR_D0, S_WR_D1, S_WR_GO, S_POLL, S_DONE
  } state_t;
  function automatic logic [3:0] clamp_dlc(input logic [3:0] d);
    return d > 4'd8 ? 4'd8 : d;
  endfunction
endpackage

// File: rtl/qar_can_prio_sel.sv
// qar_can_prio_sel: picks the valid entry with the smallest id, lowest index on ties
module qar_can_prio_sel #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]       valid,
  input  logic [N-1:0][28:0] id,
  output logic               found,
  output logic [IW-1:0]      idx
);
  logic [28:0] best;
  always_comb begin
    found = 1'b0;
    idx   = '0;
    best  = '0;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && (!found || id[i] < best)) begin
        found = 1'b1;
        idx   = IW'(i);
        best  = id[i];
      end
    end
  end
endmodule

// File: rtl/qar_can_tx_sched.sv
// qar_can_tx_sched: per-requester mailboxes, lowest-id arbitration, and the
// register-port sequence that loads, triggers and polls one CAN frame.
module qar_can_tx_sched
  import qar_can_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_id,
  input  logic [4*N_REQ-1:0]   req_dlc,
  input  logic [32*N_REQ-1:0]  req_data0,
  input  logic [32*N_REQ-1:0]  req_data1,
  output logic                 done_valid,
  output logic [2:0]           done_idx,
  output logic                 done_err,
  output logic                 busy,
  output logic                 can_write,
  output logic                 can_read,
  output logic [5:0]           can_addr,
  output logic [31:0]          can_wdata,
  input  logic [31:0]          can_rdata
);
  localparam int IW = $clog2(N_REQ);
  logic [N_REQ-1:0]       full, take;
  logic [N_REQ-1:0][28:0] mb_id;
  logic [N_REQ-1:0][3:0]  mb_dlc;
  logic [N_REQ-1:0][31:0] mb_d0, mb_d1;
  logic [IW-1:0]          sel, pick;
  logic                   found, tx_done, unused_bits;
  logic [15:0]            cnt;
  state_t                 state;
  assign req_ready   = ~full;
  assign take        = req_valid & ~full;
  assign tx_done     = can_rdata[STATUS_TX_DONE_BIT];
  assign unused_bits = ^{can_rdata, req_id};
  qar_can_prio_sel #(.N(N_REQ), .IW(IW)) u_sel (
    .valid(full),
    .id   (mb_id),
    .found(found),
    .idx  (pick)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= '0;
      mb_id  <= '0;
      mb_dlc <= '0;
      mb_d0  <= '0;
      mb_d1  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (take[i]) begin
          full[i]   <= 1'b1;
          mb_id[i]  <= req_id[i*32 +: 29];
          mb_dlc[i] <= req_dlc[i*4 +: 4];
          mb_d0[i]  <= req_data0[i*32 +: 32];
          mb_d1[i]  <= req_data1[i*32 +: 32];
        end
      end
      if (state == S_DONE) full[sel] <= 1'b0;
    end
  end
  // Bus outputs are computed for the state being entered so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sel        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done_valid <= 1'b0;
      done_idx   <= '0;
      done_err   <= 1'b0;
      can_write  <= 1'b0;
      can_read   <= 1'b0;
      can_addr   <= '0;
      can_wdata  <= '0;
    end else begin
      done_valid <= 1'b0;
      can_write  <= 1'b0;
      can_read   <= 1'b0;
      can_addr   <= '0;
      can_wdata  <= '0;
      case (state)
        S_WR_ID: begin
          state     <= S_WR_DLC;
          can_write <= 1'b1;
          can_addr  <= A_TX_DLC;
          can_wdata <= {28'b0, clamp_dlc(mb_dlc[sel])};
        end
        S_WR_DLC: begin
          state     <= S_WR_D0;
          can_write <= 1'b1;
          can_addr  <= A_TX_D0;
          can_wdata <= mb_d0[sel];
        end
        S_WR_D0: begin
          state     <= S_WR_D1;
          can_write <= 1'b1;
          can_addr  <= A_TX_D1;
          can_wdata <= mb_d1[sel];
        end
        S_WR_D1: begin
          state     <= S_WR_GO;
          can_write <= 1'b1;
          can_addr  <= A_TX_GO;
        end
        S_WR_GO: begin
          state    <= S_POLL;
          cnt      <= '0;
          can_read <= 1'b1;
          can_addr <= A_STATUS;
        end
        S_POLL: begin
          if (tx_done || cnt == 16'(TIMEOUT_CYC)) begin
            state      <= S_DONE;
            done_valid <= 1'b1;
            done_idx   <= 3'(sel);
            done_err   <= !tx_done;
          end else begin
            cnt      <= cnt == 16'hFFFF ? cnt : cnt + 16'd1;
            can_read <= 1'b1;
            can_addr <= A_STATUS;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          if (enable && found) begin
            state     <= S_WR_ID;
            sel       <= pick;
            busy      <= 1'b1;
            can_write <= 1'b1;
            can_addr  <= A_TX_ID;
            can_wdata <= {3'b0, mb_id[pick]};
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_qar_can_tx_sched.sv
// tb_qar_can_tx_sched: scoreboard bench checking write sequences, polls and completions
module tb_qar_can_tx_sched;
  localparam int N = 4;
  typedef struct { logic [5:0] a; logic [31:0] d; } wr_t;
  typedef struct { int idx; logic err; int polls; } dn_t;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, can_ok = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [32*N-1:0] req_id = '0, req_data0 = '0, req_data1 = '0;
  logic [4*N-1:0] req_dlc = '0;
  logic done_valid, done_err, busy, can_write, can_read;
  logic [2:0] done_idx;
  logic [5:0] can_addr;
  logic [31:0] can_wdata, can_rdata;
  int total = 0, bad = 0, cyc = 0, done_cnt = 0, polls = 0, k0 = 0;
  int done_cycs[$];
  wr_t wq[$];
  dn_t dq[$];
  assign can_rdata = {30'b0, can_ok, 1'b0};
  qar_can_tx_sched #(.N_REQ(N), .TIMEOUT_CYC(10)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_dlc(req_dlc), .req_data0(req_data0), .req_data1(req_data1),
    .done_valid(done_valid), .done_idx(done_idx), .done_err(done_err), .busy(busy),
    .can_write(can_write), .can_read(can_read), .can_addr(can_addr), .can_wdata(can_wdata),
    .can_rdata(can_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input int i, input logic [31:0] id, input logic [3:0] dlc,
                      input logic [31:0] d0, input logic [31:0] d1);
    req_id[i*32 +: 32]    = id;
    req_dlc[i*4 +: 4]     = dlc;
    req_data0[i*32 +: 32] = d0;
    req_data1[i*32 +: 32] = d1;
    req_valid[i]          = 1'b1;
  endtask
  task automatic expect_frame(input int idx, input logic [31:0] id, input logic [3:0] dlc,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic err, input int np);
    wq.push_back('{6'h8, {3'b0, id[28:0]}});
    wq.push_back('{6'h9, (dlc > 4'd8) ? 32'd8 : {28'b0, dlc}});
    wq.push_back('{6'hA, d0});
    wq.push_back('{6'hB, d1});
    wq.push_back('{6'hC, 32'h0});
    dq.push_back('{idx, err, np});
  endtask
  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < target) chk("wait_done", 64'(done_cnt), 64'(target));
    #1;
  endtask
  always @(negedge clk) begin
    chk("rw_excl", {63'b0, can_write & can_read}, 0);
    if (can_read) chk("rd_addr", {58'b0, can_addr}, 64'h1);
    if (!can_write && !can_read) chk("idle_bus", {26'b0, can_addr, can_wdata}, 0);
    if (can_read) polls++;
    if (can_write) begin
      if (wq.size() == 0) chk("spur_wr", {26'b0, can_addr, can_wdata}, 0);
      else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_addr", {58'b0, can_addr}, {58'b0, w.a});
        chk("wr_data", {32'b0, can_wdata}, {32'b0, w.d});
        if (can_addr == 6'hC) polls = 0;
      end
    end
    if (done_valid) begin
      if (dq.size() == 0) chk("spur_done", {61'b0, done_idx}, 64'hFF);
      else begin
        dn_t e;
        e = dq.pop_front();
        chk("done_idx", {61'b0, done_idx}, 64'(e.idx));
        chk("done_err", {63'b0, done_err}, {63'b0, e.err});
        chk("polls", 64'(polls), 64'(e.polls));
      end
      done_cycs.push_back(cyc);
      done_cnt++;
    end
  end
  task automatic chk_reset_outputs(input string tag);
    chk(tag, {req_ready, done_valid, done_idx, done_err, busy, can_write, can_read, can_addr, can_wdata},
        {4'hF, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0});
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset_in");
    rst_n = 1'b1;
    tick();
    chk_reset_outputs("reset_out");
    // single frame with exact latency
    expect_frame(2, 32'h123, 4'd4, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    load(2, 32'h123, 4'd4, 32'hDEADBEEF, 32'h0);
    k0 = cyc;
    tick();
    req_valid = '0;
    chk("ready_full", {60'b0, req_ready}, 64'hB);
    wait_done(1, 40);
    chk("latency", 64'(done_cycs[0] - k0), 8);
    chk("ready_back", {63'b0, req_ready[2]}, 1);
    // priority: ids 0x300,0x100,0x100,0x050 -> 3,1,2,0
    expect_frame(3, 32'h050, 4'd1, 32'h33, 32'h3333, 1'b0, 1);
    expect_frame(1, 32'h100, 4'd2, 32'h11, 32'h1111, 1'b0, 1);
    expect_frame(2, 32'h100, 4'd3, 32'h22, 32'h2222, 1'b0, 1);
    expect_frame(0, 32'h300, 4'd8, 32'h00, 32'h0000, 1'b0, 1);
    load(0, 32'h300, 4'd8, 32'h00, 32'h0000);
    load(1, 32'h100, 4'd2, 32'h11, 32'h1111);
    load(2, 32'h100, 4'd3, 32'h22, 32'h2222);
    load(3, 32'h050, 4'd1, 32'h33, 32'h3333);
    tick();
    req_valid = '0;
    wait_done(5, 100);
    for (int j = 2; j < 5; j++) chk("spacing", 64'(done_cycs[j] - done_cycs[j-1]), 8);
    // dlc clamp and id upper bits ignored
    expect_frame(1, 32'hE0000ABC, 4'd13, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1);
    load(1, 32'hE0000ABC, 4'd13, 32'hA5A5A5A5, 32'h5A5A5A5A);
    tick();
    req_valid = '0;
    wait_done(6, 40);
    // timeout: 11 polls then err
    can_ok = 1'b0;
    expect_frame(0, 32'h1FFFFFFF, 4'd15, 32'h1, 32'h2, 1'b1, 11);
    load(0, 32'h1FFFFFFF, 4'd15, 32'h1, 32'h2);
    tick();
    req_valid = '0;
    wait_done(7, 60);
    chk("to_cleared", {63'b0, req_ready[0]}, 1);
    can_ok = 1'b1;
    // enable gating
    enable = 1'b0;
    load(3, 32'h77, 4'd5, 32'hCAFE, 32'hF00D);
    tick();
    req_valid = '0;
    repeat (6) begin
      tick();
      chk("en_hold", {61'b0, busy, can_write, can_read}, 0);
    end
    chk("en_full", {63'b0, req_ready[3]}, 0);
    expect_frame(3, 32'h77, 4'd5, 32'hCAFE, 32'hF00D, 1'b0, 1);
    enable = 1'b1;
    wait_done(8, 40);
    // async reset during WR_D0 (k+4)
    wq.push_back('{6'h8, 32'h456});
    wq.push_back('{6'h9, 32'h2});
    load(1, 32'h456, 4'd2, 32'h9, 32'h9);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    chk("in_wr_d0", {58'b0, can_addr}, 64'hA);
    rst_n = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    repeat (3) tick();
    chk_reset_outputs("mid_reset_hold");
    rst_n = 1'b1;
    repeat (12) tick();
    chk("no_done", 64'(done_cnt), 8);
    chk("wq_empty", 64'(wq.size()), 0);
    chk("dq_empty", 64'(dq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
